// File: rtl/call_return_ctrl.sv
// Call/return sequencer between the PC logic and a FILO return-address stack.
// Optional macro CALL_TRAP_EN: an overflow/underflow also loads the PC with TRAP_VECTOR.
module call_return_ctrl #(
   parameter logic [7:0] RET_OFFSET  = 8'd1,
   parameter logic [7:0] TRAP_VECTOR = 8'hFE
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_call_req,
   input  logic       i_ret_req,
   input  logic [7:0] i_call_target,
   input  logic [7:0] i_pc_current,
   output logic       o_pc_load,
   output logic [7:0] o_pc_next,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_stack_err,
   output logic [7:0] o_stack_data_out,
   output logic       o_stack_push,
   output logic       o_stack_pull,
   input  logic [7:0] i_stack_data_in,
   input  logic       i_stack_full,
   input  logic       i_stack_empty
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH,
      S_SETTLE,
      S_PULL,
      S_LOAD,
      S_ERR
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_capture;
   logic [7:0] r_ret;
   logic [7:0] r_tgt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_ret   <= 8'h00;
         r_tgt   <= 8'h00;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_ret <= i_pc_current + RET_OFFSET;
            r_tgt <= i_call_target;
         end
      end
   end

   // Requests are only looked at in IDLE; CALL takes priority and a coincident RET is dropped.
   always_comb begin
      w_next           = r_state;
      w_capture        = 1'b0;
      o_pc_load        = 1'b0;
      o_pc_next        = 8'h00;
      o_busy           = 1'b1;
      o_done           = 1'b0;
      o_stack_err      = 1'b0;
      o_stack_push     = 1'b0;
      o_stack_pull     = 1'b0;
      o_stack_data_out = r_ret;
      unique case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_call_req) begin
               if (i_stack_full) begin
                  w_next = S_ERR;
               end else begin
                  w_next    = S_PUSH;
                  w_capture = 1'b1;
               end
            end else if (i_ret_req) begin
               w_next = i_stack_empty ? S_ERR : S_PULL;
            end
         end
         S_PUSH: begin
            o_stack_push = 1'b1;
            o_pc_load    = 1'b1;
            o_pc_next    = r_tgt;
            w_next       = S_SETTLE;
         end
         S_SETTLE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         S_PULL: begin
            o_stack_pull = 1'b1;
            w_next       = S_LOAD;
         end
         S_LOAD: begin
            o_pc_next = i_stack_data_in;
            o_pc_load = 1'b1;
            o_done    = 1'b1;
            w_next    = S_IDLE;
         end
         S_ERR: begin
            // PC_NEXT carries the trap vector here in both builds; it only matters when PC_LOAD is set.
            o_stack_err = 1'b1;
            o_done      = 1'b1;
            o_pc_next   = TRAP_VECTOR;
`ifdef CALL_TRAP_EN
            o_pc_load   = 1'b1;
`else
            o_pc_load   = 1'b0;
`endif
            w_next      = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
